// File: rtl/rv32_alu_issue_if.sv
// rv32_alu_issue_if: bundles the issue-side handshake, the ALU drive/return
// signals and the result-side handshake of rv32_alu_issue.
// The slave modport is the issue block; the master modport is its environment.
// Optional build macro ALU_ISSUE_PERF_EN adds the perf_ops/perf_illegal counters.
interface rv32_alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_pc;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_con;
  logic [31:0] alu_res;
  logic        alu_neg;
  logic        alu_carry;
  logic        alu_overflow;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_rd;
  logic [3:0]  out_flags;
  logic        out_illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_illegal;
`endif

  modport slave (
    input  in_valid, in_instr, in_rs1, in_rs2, in_pc,
    input  alu_res, alu_neg, alu_carry, alu_overflow, alu_zero,
    input  out_ready,
    output in_ready, alu_a, alu_b, alu_con,
    output out_valid, out_res, out_rd, out_flags, out_illegal
`ifdef ALU_ISSUE_PERF_EN
    , output perf_ops, output perf_illegal
`endif
  );

  modport master (
    output in_valid, in_instr, in_rs1, in_rs2, in_pc,
    output alu_res, alu_neg, alu_carry, alu_overflow, alu_zero,
    output out_ready,
    input  in_ready, alu_a, alu_b, alu_con,
    input  out_valid, out_res, out_rd, out_flags, out_illegal
`ifdef ALU_ISSUE_PERF_EN
    , input perf_ops, input perf_illegal
`endif
  );
endinterface

// File: rtl/rv32_alu_issue.sv
// rv32_alu_issue: decodes RV32I OP / OP-IMM / LUI / AUIPC into ALU control and
// operands, drives an external ALU for one cycle, registers result and flags
// and hands them downstream over valid/ready. One op in flight at a time.
// Optional build macro ALU_ISSUE_PERF_EN adds handshake/illegal counters.
module rv32_alu_issue #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  rv32_alu_issue_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [3:0] CON_ADD   = 4'b0000;
  localparam logic [3:0] CON_SUB   = 4'b0001;
  localparam logic [3:0] CON_AND   = 4'b0010;
  localparam logic [3:0] CON_OR    = 4'b0011;
  localparam logic [3:0] CON_XOR   = 4'b0100;
  localparam logic [3:0] CON_SLT   = 4'b0101;
  localparam logic [3:0] CON_SLTU  = 4'b0110;
  localparam logic [3:0] CON_AUIPC = 4'b1000;
  localparam logic [3:0] CON_LUI   = 4'b1001;
  localparam logic [3:0] CON_SLL   = 4'b1010;
  localparam logic [3:0] CON_SRA   = 4'b1011;
  localparam logic [3:0] CON_SRL   = 4'b1100;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  state_t            state_r;
  logic [XLEN-1:0]   alu_a_r;
  logic [XLEN-1:0]   alu_b_r;
  logic [3:0]        alu_con_r;
  logic [4:0]        rd_pend_r;
  logic              ill_pend_r;
  logic              out_valid_r;
  logic [XLEN-1:0]   out_res_r;
  logic [4:0]        out_rd_r;
  logic [3:0]        out_flags_r;
  logic              out_illegal_r;

  logic              in_ready_s;
  logic              accept_s;
  logic [6:0]        opcode_s;
  logic [2:0]        funct3_s;
  logic [6:0]        funct7_s;
  logic [XLEN-1:0]   imm_i_s;
  logic [XLEN-1:0]   imm_u_s;
  logic [XLEN-1:0]   shamt_rs2_s;
  logic [XLEN-1:0]   shamt_imm_s;
  logic [3:0]        raw_con_s;
  logic [XLEN-1:0]   raw_a_s;
  logic [XLEN-1:0]   raw_b_s;
  logic              dec_ill_s;
  logic [3:0]        dec_con_s;
  logic [XLEN-1:0]   dec_a_s;
  logic [XLEN-1:0]   dec_b_s;
  logic              arith_s;
  logic [3:0]        flags_s;

  assign opcode_s    = bus.in_instr[6:0];
  assign funct3_s    = bus.in_instr[14:12];
  assign funct7_s    = bus.in_instr[31:25];
  assign imm_i_s     = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign imm_u_s     = {bus.in_instr[31:12], 12'b0000_0000_0000};
  assign shamt_rs2_s = {{(XLEN-5){1'b0}}, bus.in_rs2[4:0]};
  assign shamt_imm_s = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};

  // Instruction decode: control code and operands before illegal squashing.
  always_comb begin
    raw_con_s = CON_ADD;
    raw_a_s   = bus.in_rs1;
    raw_b_s   = bus.in_rs2;
    dec_ill_s = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        case (funct3_s)
          3'b000: begin
            if (funct7_s == F7_BASE)     raw_con_s = CON_ADD;
            else if (funct7_s == F7_ALT) raw_con_s = CON_SUB;
            else                         dec_ill_s = 1'b1;
          end
          3'b001: begin
            raw_con_s = CON_SLL;
            raw_b_s   = shamt_rs2_s;
            if (funct7_s != F7_BASE) dec_ill_s = 1'b1;
            else                     dec_ill_s = 1'b0;
          end
          3'b010: begin
            raw_con_s = CON_SLT;
            if (funct7_s != F7_BASE) dec_ill_s = 1'b1;
            else                     dec_ill_s = 1'b0;
          end
          3'b011: begin
            raw_con_s = CON_SLTU;
            if (funct7_s != F7_BASE) dec_ill_s = 1'b1;
            else                     dec_ill_s = 1'b0;
          end
          3'b100: begin
            raw_con_s = CON_XOR;
            if (funct7_s != F7_BASE) dec_ill_s = 1'b1;
            else                     dec_ill_s = 1'b0;
          end
          3'b101: begin
            raw_b_s = shamt_rs2_s;
            if (funct7_s == F7_BASE)     raw_con_s = CON_SRL;
            else if (funct7_s == F7_ALT) raw_con_s = CON_SRA;
            else                         dec_ill_s = 1'b1;
          end
          3'b110: begin
            raw_con_s = CON_OR;
            if (funct7_s != F7_BASE) dec_ill_s = 1'b1;
            else                     dec_ill_s = 1'b0;
          end
          3'b111: begin
            raw_con_s = CON_AND;
            if (funct7_s != F7_BASE) dec_ill_s = 1'b1;
            else                     dec_ill_s = 1'b0;
          end
          default: dec_ill_s = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        raw_b_s = imm_i_s;
        case (funct3_s)
          3'b000: raw_con_s = CON_ADD;
          3'b010: raw_con_s = CON_SLT;
          3'b011: raw_con_s = CON_SLTU;
          3'b100: raw_con_s = CON_XOR;
          3'b110: raw_con_s = CON_OR;
          3'b111: raw_con_s = CON_AND;
          3'b001: begin
            raw_con_s = CON_SLL;
            raw_b_s   = shamt_imm_s;
            if (funct7_s != F7_BASE) dec_ill_s = 1'b1;
            else                     dec_ill_s = 1'b0;
          end
          3'b101: begin
            raw_b_s = shamt_imm_s;
            if (funct7_s == F7_BASE)     raw_con_s = CON_SRL;
            else if (funct7_s == F7_ALT) raw_con_s = CON_SRA;
            else                         dec_ill_s = 1'b1;
          end
          default: dec_ill_s = 1'b1;
        endcase
      end
      OPC_LUI: begin
        raw_con_s = CON_LUI;
        raw_a_s   = {XLEN{1'b0}};
        raw_b_s   = imm_u_s;
      end
      OPC_AUIPC: begin
        raw_con_s = CON_AUIPC;
        raw_a_s   = bus.in_pc;
        raw_b_s   = imm_u_s;
      end
      default: dec_ill_s = 1'b1;
    endcase
  end

  // Illegal ops present an all-zero ALU drive.
  assign dec_con_s = dec_ill_s ? 4'b0000 : raw_con_s;
  assign dec_a_s   = dec_ill_s ? {XLEN{1'b0}} : raw_a_s;
  assign dec_b_s   = dec_ill_s ? {XLEN{1'b0}} : raw_b_s;

  // Input acceptance: free in IDLE, tied to downstream ready while a result waits.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      IDLE:    in_ready_s = 1'b1;
      DONE:    in_ready_s = bus.out_ready;
      default: in_ready_s = 1'b0;
    endcase
  end

  assign accept_s = bus.in_valid & in_ready_s;

  // carry/overflow only mean something for add/sub; illegal ops report no flags.
  assign arith_s = (alu_con_r == CON_ADD) || (alu_con_r == CON_SUB);
  assign flags_s = ill_pend_r ? 4'b0000 :
                   {bus.alu_neg, bus.alu_carry & arith_s,
                    bus.alu_overflow & arith_s, bus.alu_zero};

  // Issue FSM: latch decode on accept, capture ALU result, hold until drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      alu_a_r       <= {XLEN{1'b0}};
      alu_b_r       <= {XLEN{1'b0}};
      alu_con_r     <= 4'b0000;
      rd_pend_r     <= 5'b00000;
      ill_pend_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      out_res_r     <= {XLEN{1'b0}};
      out_rd_r      <= 5'b00000;
      out_flags_r   <= 4'b0000;
      out_illegal_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            alu_a_r    <= dec_a_s;
            alu_b_r    <= dec_b_s;
            alu_con_r  <= dec_con_s;
            rd_pend_r  <= bus.in_instr[11:7];
            ill_pend_r <= dec_ill_s;
            state_r    <= EXEC;
          end else begin
            state_r    <= IDLE;
          end
        end
        EXEC: begin
          out_res_r     <= ill_pend_r ? {XLEN{1'b0}} : bus.alu_res;
          out_flags_r   <= flags_s;
          out_rd_r      <= rd_pend_r;
          out_illegal_r <= ill_pend_r;
          out_valid_r   <= 1'b1;
          state_r       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (bus.in_valid) begin
              alu_a_r    <= dec_a_s;
              alu_b_r    <= dec_b_s;
              alu_con_r  <= dec_con_s;
              rd_pend_r  <= bus.in_instr[11:7];
              ill_pend_r <= dec_ill_s;
              state_r    <= EXEC;
            end else begin
              state_r    <= IDLE;
            end
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.alu_a       = alu_a_r;
  assign bus.alu_b       = alu_b_r;
  assign bus.alu_con     = alu_con_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_res     = out_res_r;
  assign bus.out_rd      = out_rd_r;
  assign bus.out_flags   = out_flags_r;
  assign bus.out_illegal = out_illegal_r;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_ops_r;
  logic [31:0] perf_illegal_r;

  // Count completed output handshakes and the illegal ones among them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops_r     <= 32'd0;
      perf_illegal_r <= 32'd0;
    end else if (out_valid_r && bus.out_ready) begin
      perf_ops_r <= perf_ops_r + 32'd1;
      if (out_illegal_r) perf_illegal_r <= perf_illegal_r + 32'd1;
      else               perf_illegal_r <= perf_illegal_r;
    end else begin
      perf_ops_r     <= perf_ops_r;
      perf_illegal_r <= perf_illegal_r;
    end
  end

  assign bus.perf_ops     = perf_ops_r;
  assign bus.perf_illegal = perf_illegal_r;
`endif

endmodule

// File: tb/tb_rv32_alu_issue.sv
// tb_rv32_alu_issue: directed bench for rv32_alu_issue with a behavioural
// ALU attached to the alu_* ports. Honours ALU_ISSUE_PERF_EN when defined.
module tb_rv32_alu_issue;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_ops;
  int   exp_ill;

  rv32_alu_issue_if bus ();

  rv32_alu_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU; carry/overflow set on non-arith ops so masking is visible.
  always_comb begin
    logic [32:0] sum;
    sum = 33'd0;
    bus.alu_carry    = 1'b1;
    bus.alu_overflow = 1'b1;
    case (bus.alu_con)
      4'b0000: begin
        sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_res = sum[31:0];
        bus.alu_carry = sum[32];
        bus.alu_overflow = (bus.alu_a[31] == bus.alu_b[31]) && (sum[31] != bus.alu_a[31]);
      end
      4'b0001: begin
        bus.alu_res = bus.alu_a - bus.alu_b;
        bus.alu_carry = (bus.alu_a >= bus.alu_b);
        bus.alu_overflow = (bus.alu_a[31] != bus.alu_b[31]) && (bus.alu_res[31] != bus.alu_a[31]);
      end
      4'b0010: bus.alu_res = bus.alu_a & bus.alu_b;
      4'b0011: bus.alu_res = bus.alu_a | bus.alu_b;
      4'b0100: bus.alu_res = bus.alu_a ^ bus.alu_b;
      4'b0101: bus.alu_res = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      4'b0110: bus.alu_res = {31'd0, bus.alu_a < bus.alu_b};
      4'b1000: bus.alu_res = bus.alu_a + bus.alu_b;
      4'b1001: bus.alu_res = bus.alu_b;
      4'b1010: bus.alu_res = bus.alu_a << bus.alu_b[4:0];
      4'b1011: bus.alu_res = $signed(bus.alu_a) >>> bus.alu_b[4:0];
      4'b1100: bus.alu_res = bus.alu_a >> bus.alu_b[4:0];
      default: bus.alu_res = 32'd0;
    endcase
    bus.alu_neg  = bus.alu_res[31];
    bus.alu_zero = (bus.alu_res == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic perf_check(input string tag);
`ifdef ALU_ISSUE_PERF_EN
    check({tag, "_perf_ops"}, bus.perf_ops, 32'(exp_ops));
    check({tag, "_perf_ill"}, bus.perf_illegal, 32'(exp_ill));
`else
    check({tag, "_noperf_idle"}, 32'(bus.out_valid), 32'd0);
`endif
  endtask

  // One full transaction with out_ready held high.
  task automatic run_op(input string tag, input logic [31:0] instr, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] pc, input logic [3:0] e_con,
                        input logic [31:0] e_a, input logic [31:0] e_b, input logic [31:0] e_res,
                        input logic [3:0] e_flags, input logic [4:0] e_rd, input logic e_ill);
    @(negedge clk);
    bus.in_instr = instr; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_pc = pc;
    bus.in_valid = 1'b1;
    #1 check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_instr = 32'hFFFF_FFFF; bus.in_rs1 = 32'hDEAD_BEEF;
    bus.in_rs2 = 32'h1234_5678; bus.in_pc = 32'hCAFE_0000;
    check({tag, "_exec_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_alu_con"}, 32'(bus.alu_con), 32'(e_con));
    check({tag, "_alu_a"}, bus.alu_a, e_a);
    check({tag, "_alu_b"}, bus.alu_b, e_b);
    @(posedge clk); #1;
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_out_res"}, bus.out_res, e_res);
    check({tag, "_out_flags"}, 32'(bus.out_flags), 32'(e_flags));
    check({tag, "_out_rd"}, 32'(bus.out_rd), 32'(e_rd));
    check({tag, "_out_illegal"}, 32'(bus.out_illegal), 32'(e_ill));
    @(posedge clk); #1;
    exp_ops++;
    if (e_ill) exp_ill++;
    else       exp_ill = exp_ill;
    check({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
    perf_check(tag);
  endtask

  initial begin
    checks = 0; errors = 0; exp_ops = 0; exp_ill = 0;
    clk = 1'b0; rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_rs1 = 32'd0;
    bus.in_rs2 = 32'd0; bus.in_pc = 32'd0; bus.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_res", bus.out_res, 32'd0);
    check("rst_out_rd", 32'(bus.out_rd), 32'd0);
    check("rst_out_flags", 32'(bus.out_flags), 32'd0);
    check("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_alu_con", 32'(bus.alu_con), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    perf_check("rst");
    @(negedge clk); rst = 1'b0;

    // Arithmetic, shifts, immediates, upper-immediate forms
    run_op("add", 32'h002081B3, 32'h7FFF_FFFF, 32'h1, 32'h0, 4'b0000,
           32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1010, 5'd3, 1'b0);
    run_op("srai", 32'h4040D293, 32'hF000_0000, 32'h0, 32'h0, 4'b1011,
           32'hF000_0000, 32'h4, 32'hFF00_0000, 4'b1000, 5'd5, 1'b0);
    run_op("sll", 32'h00209333, 32'h3, 32'h21, 32'h0, 4'b1010,
           32'h3, 32'h1, 32'h6, 4'b0000, 5'd6, 1'b0);
    run_op("lui", 32'h123453B7, 32'h5555_5555, 32'h0, 32'h0, 4'b1001,
           32'h0, 32'h1234_5000, 32'h1234_5000, 4'b0000, 5'd7, 1'b0);
    run_op("auipc", 32'h00001417, 32'h0, 32'h0, 32'h100, 4'b1000,
           32'h100, 32'h1000, 32'h0000_1100, 4'b0000, 5'd8, 1'b0);
    run_op("sltu", 32'h0020B5B3, 32'h1, 32'hFFFF_FFFF, 32'h0, 4'b0110,
           32'h1, 32'hFFFF_FFFF, 32'h1, 4'b0000, 5'd11, 1'b0);
    run_op("slti", 32'hFFF0A613, 32'hFFFF_FFFB, 32'h0, 32'h0, 4'b0101,
           32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'h1, 4'b0000, 5'd12, 1'b0);
    run_op("and", 32'h0020F6B3, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 4'b0010,
           32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 4'b0000, 5'd13, 1'b0);
    run_op("srl", 32'h0020D733, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 4'b1100,
           32'h8000_0000, 32'h1F, 32'h1, 4'b0000, 5'd14, 1'b0);
    run_op("ori", 32'h0F00E793, 32'h0000_0F00, 32'h0, 32'h0, 4'b0011,
           32'h0000_0F00, 32'h0F0, 32'h0000_0FF0, 4'b0000, 5'd15, 1'b0);

    // Illegal forms: load opcode, M-extension funct7, SLLI with funct7 0100000
    run_op("ill_load", 32'h00002083, 32'h1111_1111, 32'h2222_2222, 32'h0, 4'b0000,
           32'h0, 32'h0, 32'h0, 4'b0000, 5'd1, 1'b1);
    run_op("ill_mul", 32'h022081B3, 32'h3, 32'h4, 32'h0, 4'b0000,
           32'h0, 32'h0, 32'h0, 4'b0000, 5'd3, 1'b1);
    run_op("ill_slli", 32'h40109093, 32'h3, 32'h0, 32'h0, 4'b0000,
           32'h0, 32'h0, 32'h0, 4'b0000, 5'd1, 1'b1);

    // Backpressure: SUB x9 = 5 - 5 held for 5 cycles, then back-to-back XORI
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_instr = 32'h402084B3; bus.in_rs1 = 32'h5; bus.in_rs2 = 32'h5;
    bus.in_valid = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    check("bp_res", bus.out_res, 32'd0);
    check("bp_flags", 32'(bus.out_flags), 32'(4'b0101));
    check("bp_rd", 32'(bus.out_rd), 32'd9);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_res", bus.out_res, 32'd0);
      check("bp_hold_flags", 32'(bus.out_flags), 32'(4'b0101));
      check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.in_instr = 32'hFFF0C513; bus.in_rs1 = 32'h0F0F_0F0F; bus.in_rs2 = 32'h0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1 check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    exp_ops++;
    check("b2b_exec_valid", 32'(bus.out_valid), 32'd0);
    check("b2b_alu_con", 32'(bus.alu_con), 32'(4'b0100));
    check("b2b_alu_b", bus.alu_b, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check("b2b_valid", 32'(bus.out_valid), 32'd1);
    check("b2b_res", bus.out_res, 32'hF0F0_F0F0);
    check("b2b_rd", 32'(bus.out_rd), 32'd10);
    check("b2b_flags", 32'(bus.out_flags), 32'(4'b1000));
    @(posedge clk); #1;
    exp_ops++;
    perf_check("b2b");

    // Reset while EXEC: no stale result afterwards
    @(negedge clk);
    bus.in_instr = 32'h002081B3; bus.in_rs1 = 32'h1; bus.in_rs2 = 32'h2;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rexec_valid", 32'(bus.out_valid), 32'd0);
    check("rexec_in_ready", 32'(bus.in_ready), 32'd1);
    check("rexec_alu_con", 32'(bus.alu_con), 32'd0);
    @(negedge clk); rst = 1'b0;
    exp_ops = 0; exp_ill = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rexec_no_stale", 32'(bus.out_valid), 32'd0);
      check("rexec_idle_ready", 32'(bus.in_ready), 32'd1);
    end
    perf_check("rexec");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rv32_alu_issue.md
Name: rv32_alu_issue

Overview:
Initiator side of the 4-bit-control 32-bit ALU interface. Accepts RV32I integer instructions (OP, OP-IMM, LUI, AUIPC) with operand values over a valid/ready handshake. Decodes each instruction into ALU control code and operands, drives the ALU for one cycle, then registers result and flags. Presents the result downstream over a second valid/ready handshake. Sits between the register-read stage and writeback; the ALU is instantiated outside this block and connected through the alu_* ports.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  instruction/operands valid
in_ready  output  1  block can accept this cycle
in_instr  input  32  RV32I instruction word
in_rs1  input  32  rs1 register value
in_rs2  input  32  rs2 register value
in_pc  input  32  instruction PC (AUIPC)
alu_a  output  32  ALU operand A (registered)
alu_b  output  32  ALU operand B (registered)
alu_con  output  4  ALU control code (registered)
alu_res  input  32  ALU result (combinational from ALU)
alu_neg, alu_carry, alu_overflow, alu_zero  input  1 each  ALU flags
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
out_res  output  32  registered result
out_rd  output  5  destination register, instr[11:7]
out_flags  output  4  {neg, carry, overflow, zero}
out_illegal  output  1  instruction not decodable by this block

Behaviour:
- Reset (async, rst=1): state IDLE. out_valid=0, out_res=0, out_rd=0, out_flags=0, out_illegal=0, alu_a=0, alu_b=0, alu_con=4'b0000. Any in-flight op is discarded; nothing is emitted after reset.
- FSM states IDLE, EXEC, DONE.
  - IDLE: in_ready=1; in_valid -> latch decode into alu_*, rd, illegal; go to EXEC.
  - EXEC: in_ready=0; capture alu_res and flags into out_*; out_valid=1 next cycle; go to DONE.
  - DONE: out_valid=1; out_* held stable until out_ready.
    - out_ready & in_valid: accept new op the same cycle (in_ready=out_ready in DONE); go to EXEC.
    - out_ready & !in_valid: go to IDLE.
- Latency: accept edge to out_valid = 2 cycles. Peak throughput: 1 op per 2 cycles.
- Decode, OP (opcode 0110011), requires funct7 0000000 (or 0100000 for SUB/SRA), else illegal:
  - Codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 1010, SRA 1011, SRL 1100.
  - A=rs1. B=rs2, except shifts: B={27'b0, rs2[4:0]}.
- Decode, OP-IMM (0010011): A=rs1, B=sign-extended instr[31:20].
  - ADDI 0000, SLTI 0101, SLTIU 0110, XORI 0100, ORI 0011, ANDI 0010.
  - SLLI requires funct7 0000000. SRLI/SRAI require funct7 0000000/0100000. Otherwise illegal.
  - Shifts: B={27'b0, instr[24:20]}.
- LUI (0110111): con 1001, A=0, B={instr[31:12],12'b0}.
- AUIPC (0010111): con 1000, A=pc, B={instr[31:12],12'b0}.
- Any other opcode is illegal.
- Illegal ops: alu_con=0000, A=B=0. out_res forced 0, out_flags forced 0, out_illegal=1. Still handshaken out normally; never dropped.
- Flags: neg and zero taken from the ALU for every op. carry and overflow taken only for con 0000/0001, forced 0 otherwise.
- in_* are sampled only on the accept edge; changes at other times are ignored.

Optional Feature:
ALU_ISSUE_PERF_EN
- Defined: adds outputs perf_ops[31:0] and perf_illegal[31:0].
  - perf_ops increments on each output handshake; perf_illegal increments on handshakes where out_illegal=1.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- ADD x3 (instr 0x002081B3), rs1=0x7FFFFFFF, rs2=1 -> out_res=0x80000000, flags neg=1 carry=0 overflow=1 zero=0, out_rd=3, out_valid 2 cycles after accept.
- SRAI, funct7 0100000, shamt=4, rs1=0xF0000000 -> alu_con=1011, alu_b=4. SLL with rs2=0x00000021 -> alu_b=1.
- LUI 0x12345 -> out_res=0x12345000. AUIPC imm 0x1, pc=0x100 -> out_res=0x00001100.
- Backpressure: out_ready=0 for 5 cycles -> out_* stable, in_ready=0. Then out_ready=1 with in_valid=1 -> new op accepted that cycle, next result 2 cycles later.
- Illegal (opcode 0000011, or OP with funct7 0000001) -> out_illegal=1, out_res=0, out_flags=0. Perf build: perf_illegal increments by 1.
- Assert rst during EXEC -> out_valid=0 immediately, state IDLE, in_ready=1 after release, no stale result emitted.
